// File: rtl/counter_sweep_ctrl.sv
// Sweeps an external up/down counter between lo and hi in ramp-up, ramp-down or triangle mode.
// Latency: start is accepted at the first edge, then one LOAD cycle; outputs decode combinationally from state and count.
// Backpressure: none. start is ignored while busy, and stop aborts to IDLE at the next edge.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [7:0]       n_sweeps,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             up_down,
  output logic             cnt_load,
  output logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_DN   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] M_UP  = 2'b00;
  localparam logic [1:0] M_DN  = 2'b01;
  localparam logic [1:0] M_TRI = 2'b10;

  logic [2:0]       state;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [7:0]       nsw_r;
  logic [7:0]       sweep_cnt;

  logic       up_end;
  logic       dn_end;
  logic [7:0] sweep_inc;
  logic       last_sweep;
  logic [2:0] after_sweep;

  assign up_end = (state == S_UP) && (count == hi_r);
  assign dn_end = (state == S_DN) && (count == lo_r);

  // Saturating, so an endless run (nsw_r == 0) never wraps back through a small value.
  assign sweep_inc   = (sweep_cnt == 8'hFF) ? 8'hFF : sweep_cnt + 8'd1;
  assign last_sweep  = (nsw_r != 8'd0) && (sweep_inc == nsw_r);
  assign after_sweep = last_sweep ? S_DONE : ((mode_r == M_TRI) ? S_UP : S_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mode_r    <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      nsw_r     <= '0;
      sweep_cnt <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if ((mode == 2'b11) || (lo >= hi)) begin
                err <= 1'b1;
              end else begin
                mode_r    <= mode;
                lo_r      <= lo;
                hi_r      <= hi;
                nsw_r     <= n_sweeps;
                sweep_cnt <= '0;
                state     <= S_LOAD;
              end
            end
          end
          S_LOAD: state <= (mode_r == M_DN) ? S_DN : S_UP;
          S_UP: begin
            if (up_end) begin
              if (mode_r == M_TRI) begin
                state <= S_DN;
              end else begin
                sweep_cnt <= sweep_inc;
                state     <= after_sweep;
              end
            end
          end
          S_DN: begin
            if (dn_end) begin
              sweep_cnt <= sweep_inc;
              state     <= after_sweep;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    cnt_load = (state == S_LOAD);
    up_down  = (state != S_DN);
    cnt_en   = ((state == S_UP) && (count != hi_r)) || ((state == S_DN) && (count != lo_r));
    load_val = '0;
    if (cnt_load) begin
      load_val = (mode_r == M_DN) ? hi_r : lo_r;
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a driven up/down counter, a table of start/stop decisions,
// and a sweep-trace model that expands the sweep rules into the expected per-cycle outputs.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] lo = 8'd0;
  logic [7:0] hi = 8'd0;
  logic [7:0] n_sweeps = 8'd0;
  logic [7:0] count;
  logic       cnt_en, up_down, cnt_load, busy, done, err;
  logic [7:0] load_val;

  int nvec = 0;
  int nerr = 0;

  counter_sweep_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .count(count),
    .cnt_en(cnt_en), .up_down(up_down), .cnt_load(cnt_load),
    .load_val(load_val), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // The counter the controller drives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= 8'd0;
    else if (cnt_load) count <= load_val;
    else if (cnt_en) count <= up_down ? count + 8'd1 : count - 8'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got still running, want finished");
    $fatal(1);
  end

  typedef struct {
    bit chk_cnt; int cnt; bit en; bit chk_ud; bit ud; bit ld; int lv; bit dn;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit start; bit stop; logic [1:0] mode; logic [7:0] lo; logic [7:0] hi;
    bit exp_err; bit exp_busy; logic [7:0] exp_lv;
  } tv_t;

  task automatic chk(input string name, input bit ok, input string detail);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, cnt_en == 0 && up_down == 1 && cnt_load == 0 && load_val == 0 &&
              busy == 0 && done == 0 && err == 0,
        $sformatf("got en=%b ud=%b ld=%b lv=%0d busy=%b done=%b err=%b, want 0 1 0 0 0 0 0",
                  cnt_en, up_down, cnt_load, load_val, busy, done, err));
  endtask

  task automatic push(input bit cc, input int c, input bit en, input bit cu, input bit ud,
                      input bit ld, input int lv, input bit dn);
    exp_t r;
    r.chk_cnt = cc; r.cnt = c; r.en = en; r.chk_ud = cu; r.ud = ud;
    r.ld = ld; r.lv = lv; r.dn = dn;
    q.push_back(r);
  endtask

  // Expected trace from the LOAD cycle onward: each sweep is a load (ramps, or the first
  // triangle sweep) followed by legs that visit every value between the limits once.
  task automatic build_model(input logic [1:0] m, input int l, input int h, input int sw, input bit with_done);
    q.delete();
    for (int s = 1; s <= sw; s++) begin
      if (s == 1 || m != 2'd2) push(0, 0, 0, 0, 0, 1, (m == 2'd1) ? h : l, 0);
      if (m == 2'd0 || m == 2'd2)
        for (int v = l; v <= h; v++) push(1, v, v != h, 1, 1, 0, 0, 0);
      if (m == 2'd1 || m == 2'd2)
        for (int v = h; v >= l; v--) push(1, v, v != l, 1, 0, 0, 0, 0);
    end
    if (with_done) push(1, (m == 2'd0) ? h : l, 0, 1, 1, 0, 0, 1);
  endtask

  task automatic run_sweep(input string nm, input logic [1:0] m, input int l, input int h,
                           input int n, input int msw, input int stop_at, input bit jitter);
    exp_t r;
    int fin;
    int lim;
    build_model(m, l, h, (n == 0) ? msw : n, n != 0);
    lim = (n == 0) ? q.size() - 1 : q.size() - 2;
    if (stop_at > lim) stop_at = lim;
    stop = 0; start = 1; mode = m; lo = 8'(l); hi = 8'(h); n_sweeps = 8'(n);
    step();
    start = 0;
    for (int i = 0; i < q.size(); i++) begin
      r = q[i];
      chk(nm, (!r.chk_cnt || count == 8'(r.cnt)) && cnt_en == r.en && (!r.chk_ud || up_down == r.ud) &&
              cnt_load == r.ld && load_val == 8'(r.lv) && done == r.dn && busy == 1,
          $sformatf("cyc %0d got cnt=%0d en=%b ud=%b ld=%b lv=%0d done=%b busy=%b want cnt=%0d en=%b ud=%b ld=%b lv=%0d done=%b busy=1",
                    i, count, cnt_en, up_down, cnt_load, load_val, done, busy,
                    r.cnt, r.en, r.ud, r.ld, r.lv, r.dn));
      if (stop_at > 0 && i == stop_at) begin
        stop = 1;
        step();
        stop = 0; start = 0;
        fin = r.ld ? r.lv : (r.en ? (r.ud ? r.cnt + 1 : r.cnt - 1) : r.cnt);
        chk({nm, "_stop"}, busy == 0 && cnt_en == 0 && done == 0 && count == 8'(fin),
            $sformatf("got busy=%b en=%b done=%b cnt=%0d want 0 0 0 %0d", busy, cnt_en, done, count, fin));
        step(); step();
        chk({nm, "_frozen"}, busy == 0 && done == 0 && count == 8'(fin),
            $sformatf("got busy=%b done=%b cnt=%0d want 0 0 %0d", busy, done, count, fin));
        return;
      end
      if (jitter) begin
        mode = 2'($urandom); lo = 8'($urandom); hi = 8'($urandom);
        n_sweeps = 8'($urandom); start = 1'($urandom);
      end
      step();
    end
    start = 0;
    fin = (m == 2'd0) ? h : l;
    chk({nm, "_idle"}, busy == 0 && done == 0 && cnt_en == 0 && count == 8'(fin),
        $sformatf("got busy=%b done=%b en=%b cnt=%0d want 0 0 0 %0d", busy, done, cnt_en, count, fin));
  endtask

  tv_t tv[10];

  initial begin
    tv[0] = '{1, 0, 2'b00, 8'd5,   8'd5,   1, 0, 8'd0};
    tv[1] = '{1, 0, 2'b11, 8'd1,   8'd9,   1, 0, 8'd0};
    tv[2] = '{1, 0, 2'b00, 8'd9,   8'd1,   1, 0, 8'd0};
    tv[3] = '{1, 1, 2'b00, 8'd2,   8'd7,   0, 1, 8'd2};
    tv[4] = '{0, 1, 2'b00, 8'd2,   8'd7,   0, 0, 8'd0};
    tv[5] = '{1, 0, 2'b01, 8'd2,   8'd7,   0, 1, 8'd7};
    tv[6] = '{1, 0, 2'b10, 8'd0,   8'd255, 0, 1, 8'd0};
    tv[7] = '{0, 0, 2'b01, 8'd3,   8'd4,   0, 0, 8'd0};
    tv[8] = '{1, 0, 2'b01, 8'd254, 8'd255, 0, 1, 8'd255};
    tv[9] = '{1, 0, 2'b11, 8'd5,   8'd5,   1, 0, 8'd0};

    #12;
    chk_reset_outs("reset_hold");
    @(negedge clk);
    rst = 1;
    step();
    chk_reset_outs("reset_release");

    for (int i = 0; i < 10; i++) begin
      start = tv[i].start; stop = tv[i].stop; mode = tv[i].mode;
      lo = tv[i].lo; hi = tv[i].hi; n_sweeps = 8'd1;
      step();
      start = 0; stop = 0;
      chk($sformatf("table%0d", i),
          err == tv[i].exp_err && busy == tv[i].exp_busy && cnt_load == tv[i].exp_busy &&
          load_val == tv[i].exp_lv && done == 0,
          $sformatf("got err=%b busy=%b ld=%b lv=%0d done=%b want %b %b %b %0d 0",
                    err, busy, cnt_load, load_val, done, tv[i].exp_err, tv[i].exp_busy,
                    tv[i].exp_busy, tv[i].exp_lv));
      if (busy) begin
        stop = 1;
        step();
        stop = 0;
      end else begin
        step();
      end
      chk($sformatf("table%0d_after", i), err == 0 && busy == 0,
          $sformatf("got err=%b busy=%b want 0 0", err, busy));
    end

    run_sweep("ramp_up_3_6", 2'd0, 3, 6, 2, 0, 0, 0);
    run_sweep("tri_10_12", 2'd2, 10, 12, 1, 0, 0, 0);
    run_sweep("tri_10_12_x2", 2'd2, 10, 12, 2, 0, 0, 1);
    run_sweep("ramp_dn_full", 2'd1, 0, 255, 1, 0, 0, 0);
    run_sweep("ramp_up_full", 2'd0, 0, 255, 1, 0, 0, 0);
    run_sweep("tri_endless_stop", 2'd2, 20, 24, 0, 3, 13, 0);
    run_sweep("endless_sat", 2'd0, 0, 1, 0, 260, 779, 0);

    for (int it = 0; it < 30; it++) begin
      int l, h, n, sa;
      logic [1:0] m;
      m = 2'($urandom_range(2, 0));
      if (it % 5 == 0) begin
        l = $urandom_range(50, 0); h = l + $urandom_range(100, 20);
      end else begin
        l = $urandom_range(250, 0); h = l + $urandom_range(255 - l, 1);
        if (h > l + 6) h = l + 6;
      end
      n = $urandom_range(3, 0);
      sa = (n == 0 || $urandom_range(3, 0) == 0) ? $urandom_range(40, 1) : 0;
      run_sweep($sformatf("rand%0d", it), m, l, h, n, 3, sa, 1);
    end

    // Asynchronous reset in the middle of a sweep, then a restart.
    start = 1; mode = 2'd0; lo = 8'd0; hi = 8'd200; n_sweeps = 8'd1;
    step();
    start = 0;
    repeat (10) step();
    chk("pre_reset_busy", busy == 1 && cnt_en == 1, $sformatf("got busy=%b en=%b want 1 1", busy, cnt_en));
    #2;
    rst = 0;
    #1;
    chk_reset_outs("async_reset");
    @(negedge clk);
    chk_reset_outs("async_reset_held");
    rst = 1;
    run_sweep("after_reset", 2'd1, 2, 4, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
